// File: rtl/envio_resposta_pkg.sv
// envio_resposta_pkg: FSM encoding and response byte constants shared by the serializer, sensor stage and benches
package envio_resposta_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SEND_CMD = 3'd1;
    localparam logic [2:0] ST_WAIT_CMD = 3'd2;
    localparam logic [2:0] ST_SEND_VAL = 3'd3;
    localparam logic [2:0] ST_WAIT_VAL = 3'd4;
    localparam logic [2:0] ST_GAP      = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        SEND_CMD = ST_SEND_CMD,
        WAIT_CMD = ST_WAIT_CMD,
        SEND_VAL = ST_SEND_VAL,
        WAIT_VAL = ST_WAIT_VAL,
        GAP      = ST_GAP
    } state_t;

    localparam logic [7:0] RESP_07 = 8'h07;
    localparam logic [7:0] RESP_08 = 8'h08;
    localparam logic [7:0] RESP_09 = 8'h09;
    localparam logic [7:0] RESP_0A = 8'h0A;
    localparam logic [7:0] RESP_0B = 8'h0B;
    localparam logic [7:0] RESP_0D = 8'h0D;
    localparam logic [7:0] RESP_0E = 8'h0E;
    localparam logic [7:0] RESP_1F = 8'h1F;
    localparam logic [7:0] RESP_45 = 8'h45;
    localparam logic [7:0] RESP_AA = 8'hAA;
    localparam logic [7:0] RESP_AB = 8'hAB;
    localparam logic [7:0] RESP_FF = 8'hFF;

    localparam int N_RESP = 12;
    localparam logic [7:0] RESP_CODES [N_RESP] = '{
        RESP_07, RESP_08, RESP_09, RESP_0A, RESP_0B, RESP_0D,
        RESP_0E, RESP_1F, RESP_45, RESP_AA, RESP_AB, RESP_FF
    };

endpackage

// File: rtl/envio_resposta.sv
// envio_resposta: sends each new sensor response as a command/value byte pair through the uart_tx handshake
module envio_resposta
    import envio_resposta_pkg::*;
#(
    parameter int GAP_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dadosPodemSerEnviados,
    input  logic [7:0] response_command,
    input  logic [7:0] response_value,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       overrun
);

    localparam int CW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;

    state_t        state;
    logic          prev;
    logic          pend_valid;
    logic [7:0]    cur_cmd;
    logic [7:0]    cur_val;
    logic [7:0]    pend_cmd;
    logic [7:0]    pend_val;
    logic [CW-1:0] gap_cnt;
    logic          rise;
    logic          gap_end;

    assign rise     = dadosPodemSerEnviados & ~prev;
    assign gap_end  = state == GAP && gap_cnt == '0;
    assign tx_start = (state == SEND_CMD || state == SEND_VAL) && !tx_busy;
    assign busy     = state != IDLE;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            prev       <= 1'b1;
            pend_valid <= 1'b0;
            overrun    <= 1'b0;
            tx_data    <= 8'h00;
            cur_cmd    <= 8'h00;
            cur_val    <= 8'h00;
            pend_cmd   <= 8'h00;
            pend_val   <= 8'h00;
            gap_cnt    <= '0;
        end else begin
            prev <= dadosPodemSerEnviados;
            case (state)
                IDLE: if (rise) begin
                    cur_cmd <= response_command;
                    cur_val <= response_value;
                    tx_data <= response_command;
                    state   <= SEND_CMD;
                end
                SEND_CMD: if (!tx_busy) state <= WAIT_CMD;
                WAIT_CMD: if (tx_done) begin
                    tx_data <= cur_val;
                    state   <= SEND_VAL;
                end
                SEND_VAL: if (!tx_busy) state <= WAIT_VAL;
                WAIT_VAL: if (tx_done) begin
                    gap_cnt <= CW'(GAP_CYCLES - 1);
                    state   <= GAP;
                end
                GAP: if (!gap_end) begin
                    gap_cnt <= gap_cnt - 1'b1;
                end else if (pend_valid) begin
                    cur_cmd    <= pend_cmd;
                    cur_val    <= pend_val;
                    tx_data    <= pend_cmd;
                    pend_valid <= 1'b0;
                    state      <= SEND_CMD;
                end else if (rise) begin
                    cur_cmd <= response_command;
                    cur_val <= response_value;
                    tx_data <= response_command;
                    state   <= SEND_CMD;
                end else begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // on the final gap cycle the pending entry has just been promoted, so a new edge refills it without overrun
            if (rise && state != IDLE && !(gap_end && !pend_valid)) begin
                pend_cmd   <= response_command;
                pend_val   <= response_value;
                pend_valid <= 1'b1;
                if (pend_valid && !gap_end) overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_envio_resposta.sv
// tb_envio_resposta: directed and random frames checked by a response-level model through a byte scoreboard
module tb_envio_resposta;
    import envio_resposta_pkg::*;

    localparam int GAP  = 5;
    localparam int ULEN = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       din;
    logic [7:0] cmd;
    logic [7:0] val;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       overrun;

    always #5 clock = ~clock;

    envio_resposta #(.GAP_CYCLES(GAP)) dut (
        .clock(clock),
        .reset(reset),
        .dadosPodemSerEnviados(din),
        .response_command(cmd),
        .response_value(val),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .busy(busy),
        .overrun(overrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endfunction

    logic [7:0] q[$];

    // uart_tx stand-in: done arrives ULEN cycles after start; hold adds extra busy time
    int   u_cnt = 0;
    int   hold  = 0;
    logic hold_en;
    logic st_s = 1'b0;

    always @(negedge clock) st_s = tx_start;

    task automatic step();
        @(posedge clock);
        #1;
        tx_done = 1'b0;
        if (st_s) u_cnt = ULEN - 1;
        else if (u_cnt > 0) begin
            u_cnt--;
            if (u_cnt == 0) tx_done = 1'b1;
        end
        if (hold > 0) hold--;
        else if (hold_en && u_cnt == 0 && !tx_done && $urandom_range(0, 59) == 0) hold = $urandom_range(1, 25);
        tx_busy = u_cnt > 0 || hold > 0;
    endtask

    task automatic pulse(input logic [7:0] c, input logic [7:0] v);
        din = 1'b1;
        cmd = c;
        val = v;
        step();
        din = 1'b0;
        step();
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            step();
            if (!busy && q.size() == 0 && u_cnt == 0 && hold == 0) return;
        end
        n_checks++;
        $display("FAIL idle_timeout: still busy after %0d cycles, %0d bytes expected", max, q.size());
    endtask

    task automatic wait_dones(input int n);
        int c = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (tx_done) c++;
            if (c == n) return;
        end
        n_checks++;
        $display("FAIL done_timeout: saw %0d of %0d tx_done", c, n);
    endtask

    // response-level model: a frame is in flight or not, plus one pending slot
    logic       m_active = 1'b0;
    logic       m_pend_v = 1'b0;
    logic       m_ovr    = 1'b0;
    logic       m_prev   = 1'b1;
    logic [7:0] m_pc;
    logic [7:0] m_pv;
    logic       val_inflight = 1'b0;
    int         cyc    = 0;
    int         end_at = -1;
    int         starts = 0;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            m_active     = 1'b0;
            m_pend_v     = 1'b0;
            m_ovr        = 1'b0;
            m_prev       = 1'b1;
            val_inflight = 1'b0;
            starts       = 0;
            end_at       = -1;
            q.delete();
        end else begin
            check("busy", busy, m_active);
            check("overrun", overrun, m_ovr);
            if (tx_start) begin
                starts++;
                if (starts % 2 == 0) val_inflight = 1'b1;
            end
            if (tx_done && val_inflight) begin
                val_inflight = 1'b0;
                end_at = cyc + GAP;
            end
            if (cyc == end_at) begin
                if (m_pend_v) begin
                    q.push_back(m_pc);
                    q.push_back(m_pv);
                    m_pend_v = 1'b0;
                end else m_active = 1'b0;
            end
            if (din && !m_prev) begin
                if (!m_active) begin
                    q.push_back(cmd);
                    q.push_back(val);
                    m_active = 1'b1;
                end else begin
                    if (m_pend_v) m_ovr = 1'b1;
                    m_pc = cmd;
                    m_pv = val;
                    m_pend_v = 1'b1;
                end
            end
            m_prev = din;
        end
    end

    logic       held_v = 1'b0;
    logic       prev_st = 1'b0;
    logic [7:0] held;

    always @(negedge clock) begin
        if (reset) begin
            held_v  = 1'b0;
            prev_st = 1'b0;
        end else begin
            if (tx_start) begin
                check("start_gap", prev_st, 1'b0);
                check("start_uart_idle", tx_busy, 1'b0);
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_start: tx_data %0h with no byte expected", tx_data);
                end else check("tx_data", tx_data, q.pop_front());
                held   = tx_data;
                held_v = 1'b1;
            end else if (held_v) check("data_hold", tx_data, held);
            if (tx_done) held_v = 1'b0;
            prev_st = tx_start;
        end
    end

    int   n_hold;
    logic got;
    int   odds;

    initial begin
        reset = 1'b1; din = 1'b1; cmd = 8'h00; val = 8'h00;
        tx_busy = 1'b0; tx_done = 1'b0; hold_en = 1'b0;
        repeat (3) step();
        @(negedge clock);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        step();
        reset = 1'b0;
        repeat (30) step();
        din = 1'b0;
        step();

        din = 1'b1; cmd = RESP_09; val = 8'h1A;
        step();
        din = 1'b0;
        @(negedge clock);
        check("first_start", tx_start, 1'b1);
        check("first_cmd", tx_data, RESP_09);
        wait_idle(200);

        din = 1'b1; cmd = RESP_0B; val = RESP_45; hold = 20; tx_busy = 1'b1;
        n_hold = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            din = 1'b0;
            n_hold++;
            @(negedge clock);
            if (tx_start) got = 1'b1;
        end
        check("holdoff_cycles", n_hold, 20);
        wait_idle(200);

        pulse(RESP_0D, RESP_07);
        repeat (4) step();
        pulse(RESP_0D, 8'h19);
        wait_idle(300);

        pulse(RESP_0D, 8'h05);
        pulse(RESP_0D, 8'h01);
        pulse(RESP_0D, 8'h02);
        wait_idle(300);
        @(negedge clock);
        check("overrun_sticky", overrun, 1'b1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        check("overrun_cleared", overrun, 1'b0);

        for (int p = 0; p < 2; p++) begin
            pulse(RESP_07, RESP_0E);
            if (p == 0) pulse(RESP_08, RESP_1F);
            wait_dones(2);
            repeat (GAP) step();
            pulse(RESP_AA, RESP_AB);
            wait_idle(300);
        end

        pulse(RESP_09, RESP_0A);
        pulse(RESP_0D, RESP_45);
        wait_dones(1);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        check("midrst_tx_start", tx_start, 1'b0);
        check("midrst_tx_data", tx_data, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_overrun", overrun, 1'b0);
        wait_idle(300);

        hold_en = 1'b1;
        for (int b = 0; b < 6; b++) begin
            odds = b % 3 == 0 ? 3 : b % 3 == 1 ? 12 : 40;
            for (int i = 0; i < 500; i++) begin
                reset = $urandom_range(0, 799) == 0;
                if (din) din = $urandom_range(0, 3) != 0;
                else din = $urandom_range(0, odds) == 0;
                cmd = $urandom_range(0, 1) != 0 ? RESP_CODES[$urandom_range(0, N_RESP - 1)] : 8'($urandom);
                val = 8'($urandom);
                step();
            end
        end
        din = 1'b0; reset = 1'b0; hold_en = 1'b0;
        wait_idle(3000);
        @(negedge clock);
        check("scoreboard_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
